// File: rtl/uio_arb_pkg.sv
// Shared types and constants for the uio pin-bank arbiter.
package uio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_e;

  localparam int unsigned UIO_W    = 8;
  localparam int unsigned MAX_NREQ = 4;
  localparam int unsigned IDX_W    = 2;
  localparam int unsigned HOLD_W   = 8;
  localparam int unsigned PAD_W    = UIO_W * MAX_NREQ;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request after last_winner, modulo NREQ.
module rr_pick
  import uio_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic [MAX_NREQ-1:0] req,
  input  logic [IDX_W-1:0]    last_winner,
  output logic                found,
  output logic [IDX_W-1:0]    winner
);

  logic [IDX_W-1:0] w_idx;

  // Scan from the farthest candidate down so the nearest one after last_winner wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    w_idx  = '0;
    for (int k = int'(NREQ); k >= 1; k--) begin
      w_idx = IDX_W'((int'(last_winner) + k) % int'(NREQ));
      if (req[w_idx]) begin
        found  = 1'b1;
        winner = w_idx;
      end
    end
  end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the uio pad bank with an all-input turnaround gap between owners.
// Define UIO_ARB_TIMEOUT_EN to force release after MAX_HOLD consecutive owned cycles.
module uio_bus_arbiter
  import uio_arb_pkg::*;
#(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned TURN_CYC = 1,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [NREQ-1:0]       req,
  input  logic [UIO_W*NREQ-1:0] wdata,
  input  logic [UIO_W*NREQ-1:0] woe,
  output logic [NREQ-1:0]       gnt,
  output logic [UIO_W-1:0]      uio_out,
  output logic [UIO_W-1:0]      uio_oe,
  output logic                  busy
);

  if (NREQ < 2 || NREQ > MAX_NREQ || TURN_CYC > 3 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad
    $error("uio_bus_arbiter: parameter out of legal range");
  end

  state_e           r_state, w_state_d;
  logic [IDX_W-1:0] r_owner, w_owner_d;
  logic [IDX_W-1:0] r_last, w_last_d;
  logic [1:0]       r_turn, w_turn_d;

  logic [MAX_NREQ-1:0] w_req_pad;
  logic [PAD_W-1:0]    w_wdata_pad;
  logic [PAD_W-1:0]    w_woe_pad;
  logic                w_found;
  logic [IDX_W-1:0]    w_winner;
  logic                w_timeout;
  logic                w_release;

  assign w_req_pad   = MAX_NREQ'(req);
  assign w_wdata_pad = PAD_W'(wdata);
  assign w_woe_pad   = PAD_W'(woe);

  rr_pick #(
    .NREQ(NREQ)
  ) u_rr_pick (
    .req         (w_req_pad),
    .last_winner (r_last),
    .found       (w_found),
    .winner      (w_winner)
  );

`ifdef UIO_ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] r_hold, w_hold_d;

  // r_hold counts owned cycles already completed, so the last allowed cycle sees MAX_HOLD-1.
  assign w_timeout = (r_hold == HOLD_W'(MAX_HOLD - 1));
  assign w_hold_d  = (r_state == GRANT && !w_release) ? r_hold + 1'b1 : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
    end else begin
      r_hold <= w_hold_d;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  assign w_release = !w_req_pad[r_owner] || !ena || w_timeout;

  always_comb begin
    w_state_d = r_state;
    w_owner_d = r_owner;
    w_last_d  = r_last;
    w_turn_d  = r_turn;
    case (r_state)
      IDLE: begin
        if (ena && w_found) begin
          w_owner_d = w_winner;
          w_last_d  = w_winner;
          w_state_d = GRANT;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_state_d = (TURN_CYC == 0) ? IDLE : TURN;
          w_turn_d  = '0;
        end
      end
      TURN: begin
        if (r_turn == 2'(TURN_CYC - 1)) begin
          w_state_d = IDLE;
          w_turn_d  = '0;
        end else begin
          w_turn_d = r_turn + 1'b1;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_last  <= IDX_W'(NREQ - 1);
      r_turn  <= '0;
    end else begin
      r_state <= w_state_d;
      r_owner <= w_owner_d;
      r_last  <= w_last_d;
      r_turn  <= w_turn_d;
    end
  end

  // Pads decode straight off registered state so reset releases them asynchronously.
  always_comb begin
    gnt     = '0;
    uio_out = '0;
    uio_oe  = '0;
    if (r_state == GRANT) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        gnt[i] = (r_owner == IDX_W'(i));
      end
      uio_out = w_wdata_pad[{r_owner, 3'b000} +: UIO_W];
      uio_oe  = w_woe_pad[{r_owner, 3'b000} +: UIO_W];
    end
  end

  assign busy = (r_state != IDLE);

endmodule
